// File: rtl/murax_uart_pkg.sv
// Shared definitions for the board UART transmit path: frame-state encoding,
// data width, and the bit period for the 12 MHz board clock at 115200 baud.
package murax_uart_pkg;

  localparam int UART_DATA_BITS  = 8;
  localparam int CLK_DIV_DEFAULT = 104;  // 12 MHz / 115200

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_e;

endpackage

// File: rtl/uart_tx_serializer.sv
// 8N1 frame serializer: accepts a byte on i_load while idle and shifts out
// start bit, eight data bits LSB first, and a stop bit, each held CLK_DIV cycles.
// Reusable across the iCE40 board toplevels.
module uart_tx_serializer
  import murax_uart_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_load,
  input  logic [UART_DATA_BITS-1:0] i_byte,
  output logic                      o_busy,
  output logic                      o_done,
  output logic                      o_txd
);

  localparam int                CNT_W     = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0]  BAUD_LAST = CNT_W'(CLK_DIV - 1);
  localparam int                BIT_W     = $clog2(UART_DATA_BITS);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(UART_DATA_BITS - 1);

  tx_state_e                 r_state;
  tx_state_e                 w_state_nxt;
  logic [CNT_W-1:0]          r_baud_cnt;
  logic [CNT_W-1:0]          w_baud_nxt;
  logic [BIT_W-1:0]          r_bit_cnt;
  logic [BIT_W-1:0]          w_bit_nxt;
  logic [UART_DATA_BITS-1:0] r_shift;
  logic [UART_DATA_BITS-1:0] w_shift_nxt;
  logic                      r_txd;
  logic                      w_txd_nxt;
  logic                      w_baud_tc;
  logic                      w_done;

  assign w_baud_tc = (r_baud_cnt == BAUD_LAST);
  assign o_busy    = (r_state != IDLE);
  assign o_done    = w_done;
  assign o_txd     = r_txd;

  // Next-state, counter, shift and pin-value decode; the pin value is computed
  // one cycle ahead and registered so io_txd is glitch-free.
  always_comb begin
    // NOTE: every variable assigned here gets a default first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    w_state_nxt = r_state;
    w_baud_nxt  = r_baud_cnt + CNT_W'(1);
    w_bit_nxt   = r_bit_cnt;
    w_shift_nxt = r_shift;
    w_txd_nxt   = r_txd;
    w_done      = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_baud_nxt = '0;
        w_bit_nxt  = '0;
        w_txd_nxt  = 1'b1;
        if (i_load) begin
          w_state_nxt = START;
          w_shift_nxt = i_byte;
          w_txd_nxt   = 1'b0;
        end
      end
      START: begin
        if (w_baud_tc) begin
          w_state_nxt = DATA;
          w_baud_nxt  = '0;
          w_txd_nxt   = r_shift[0];
        end
      end
      DATA: begin
        if (w_baud_tc) begin
          w_baud_nxt  = '0;
          w_shift_nxt = r_shift >> 1;
          if (r_bit_cnt == BIT_LAST) begin
            w_state_nxt = STOP;
            w_bit_nxt   = '0;
            w_txd_nxt   = 1'b1;
          end else begin
            w_bit_nxt = r_bit_cnt + BIT_W'(1);
            w_txd_nxt = r_shift[1];
          end
        end
      end
      STOP: begin
        if (w_baud_tc) begin
          w_state_nxt = IDLE;
          w_baud_nxt  = '0;
          w_done      = 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_txd_nxt   = 1'b1;
      end
    endcase
  end

  // Frame state, counters, shift register and registered pin.
  always_ff @(posedge i_clk) begin
    // NOTE: reset is sampled on the clock edge, so a mid-frame reset forces the
    // pin high on the next edge rather than immediately.
    if (!i_rst_n) begin
      r_state    <= IDLE;
      r_baud_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_txd      <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make every register take its new value
      // together at the edge, independent of statement order.
      r_state    <= w_state_nxt;
      r_baud_cnt <= w_baud_nxt;
      r_bit_cnt  <= w_bit_nxt;
      r_shift    <= w_shift_nxt;
      r_txd      <= w_txd_nxt;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART TX pin between two byte requesters. Round-robin at byte
// granularity: on a tie the requester not served last wins. The frame itself
// is produced by uart_tx_serializer.
module uart_tx_arbiter
  import murax_uart_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
  input  logic                      io_mainClk,
  input  logic                      io_resetn,
  input  logic                      io_req0_valid,
  input  logic [UART_DATA_BITS-1:0] io_req0_data,
  output logic                      io_req0_ready,
  input  logic                      io_req1_valid,
  input  logic [UART_DATA_BITS-1:0] io_req1_data,
  output logic                      io_req1_ready,
  output logic                      io_txd,
  output logic                      io_busy,
  output logic [1:0]                io_grant
);

  logic                      w_busy;
  logic                      w_done;
  logic                      w_ready0;
  logic                      w_ready1;
  logic                      w_load;
  logic [UART_DATA_BITS-1:0] w_byte;
  logic                      r_last;   // requester served last: 0 or 1
  logic [1:0]                r_grant;

  // Ready only in IDLE and outside reset; a tie goes to the requester not
  // served last, so at most one ready is ever high.
  assign w_ready0 = io_resetn && !w_busy && io_req0_valid && (!io_req1_valid || r_last);
  assign w_ready1 = io_resetn && !w_busy && io_req1_valid && (!io_req0_valid || !r_last);
  assign w_load   = w_ready0 || w_ready1;
  assign w_byte   = w_ready1 ? io_req1_data : io_req0_data;

  // Pointer and grant: set on handshake, grant cleared as the stop bit ends.
  always_ff @(posedge io_mainClk) begin
    if (!io_resetn) begin
      r_last  <= 1'b1;
      r_grant <= 2'b00;
    end else if (w_load) begin
      r_last  <= w_ready1;
      r_grant <= {w_ready1, w_ready0};
    end else if (w_done) begin
      r_grant <= 2'b00;
    end
  end

  uart_tx_serializer #(
    .CLK_DIV (CLK_DIV)
  ) u_serializer (
    .i_clk   (io_mainClk),
    .i_rst_n (io_resetn),
    .i_load  (w_load),
    .i_byte  (w_byte),
    .o_busy  (w_busy),
    .o_done  (w_done),
    .o_txd   (io_txd)
  );

  assign io_req0_ready = w_ready0;
  assign io_req1_ready = w_ready1;
  assign io_busy       = w_busy;
  assign io_grant      = r_grant;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: a fast instance (CLK_DIV=4) run in lockstep
// against a frame-timer reference model, plus a CLK_DIV=104 instance decoded
// by a UART monitor.
module tb_uart_tx_arbiter;

  localparam int D     = 4;
  localparam int DS    = 104;
  localparam int FRAME = 10 * D;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       rst_req;
  logic       v0, v1, r0, r1, txd, busy;
  logic [7:0] d0, d1;
  logic [1:0] grant;
  logic       sv0, sv1, sr0, sr1, stxd, sbusy;
  logic [7:0] sd0, sd1;
  logic [1:0] sgrant;

  uart_tx_arbiter #(.CLK_DIV(D)) dut (
    .io_mainClk(clk), .io_resetn(rst_n),
    .io_req0_valid(v0), .io_req0_data(d0), .io_req0_ready(r0),
    .io_req1_valid(v1), .io_req1_data(d1), .io_req1_ready(r1),
    .io_txd(txd), .io_busy(busy), .io_grant(grant)
  );

  uart_tx_arbiter #(.CLK_DIV(DS)) dut_slow (
    .io_mainClk(clk), .io_resetn(rst_n),
    .io_req0_valid(sv0), .io_req0_data(sd0), .io_req0_ready(sr0),
    .io_req1_valid(sv1), .io_req1_data(sd1), .io_req1_ready(sr1),
    .io_txd(stxd), .io_busy(sbusy), .io_grant(sgrant)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Requester byte streams and last observed handshakes.
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic       hs0 = 1'b0;
  logic       hs1 = 1'b0;

  // Reference model: m_t counts cycles into the current frame (0 = idle).
  int         m_t     = 0;
  logic [7:0] m_byte  = 8'h00;
  int         m_owner = 0;
  int         m_last  = 1;

  function automatic logic [1:0] m_ready();
    logic [1:0] rd;
    rd = 2'b00;
    if (rst_n === 1'b1 && m_t == 0) begin
      if (v0 && v1) rd = (m_last == 1) ? 2'b01 : 2'b10;
      else          rd = {v1, v0};
    end
    return rd;
  endfunction

  function automatic logic m_txd();
    int slot;
    if (m_t == 0) return 1'b1;
    slot = (m_t - 1) / D;
    if (slot == 0) return 1'b0;
    if (slot == 9) return 1'b1;
    return m_byte[slot-1];
  endfunction

  // {txd, busy, grant[1:0], ready1, ready0}
  function automatic logic [5:0] exp_vec();
    logic [1:0] g;
    g = (m_t == 0) ? 2'b00 : ((m_owner == 1) ? 2'b10 : 2'b01);
    return {m_txd(), (m_t != 0), g, m_ready()};
  endfunction

  function automatic logic [5:0] dut_vec();
    return {txd, busy, grant, r1, r0};
  endfunction

  always @(posedge clk) begin
    if (rst_n !== 1'b1) begin
      m_t    <= 0;
      m_last <= 1;
    end else if (m_t == 0) begin
      if (m_ready() == 2'b01) begin
        m_t <= 1; m_byte <= d0; m_owner <= 0; m_last <= 0;
      end else if (m_ready() == 2'b10) begin
        m_t <= 1; m_byte <= d1; m_owner <= 1; m_last <= 1;
      end
    end else begin
      m_t <= (m_t == FRAME) ? 0 : m_t + 1;
    end
  end

  task automatic drive_streams();
    logic [7:0] tmp;
    rst_n = rst_req;
    if (hs0 && q0.size() > 0) tmp = q0.pop_front();
    if (hs1 && q1.size() > 0) tmp = q1.pop_front();
    v0 = (q0.size() > 0);
    d0 = v0 ? q0[0] : 8'($urandom);
    v1 = (q1.size() > 0);
    d1 = v1 ? q1[0] : 8'($urandom);
  endtask

  // Advance one cycle: drive just after the edge, observe 2 time units later.
  task automatic cycle_step(output logic [5:0] got, output logic [5:0] want);
    @(posedge clk); #1;
    drive_streams();
    #1;
    got  = dut_vec();
    want = exp_vec();
    hs0  = r0;
    hs1  = r1;
  endtask

  task automatic test_reset();
    logic [5:0] got, want;
    q0.delete(); q1.delete();
    q0.push_back(8'($urandom));
    q1.push_back(8'($urandom));
    rst_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle_step(got, want);
      n_checks++;
      if (got !== 6'b100000) begin
        n_errors++;
        $display("FAIL reset_hold cyc=%0d got=%b want=100000 (txd,busy,grant,rdy1,rdy0)", cyc, got);
      end
    end
    rst_req = 1'b1;
    cycle_step(got, want);
    n_checks++;
    if (got[1:0] !== 2'b01) begin
      n_errors++;
      $display("FAIL reset_first_winner cyc=%0d got ready=%b want 01", cyc, got[1:0]);
    end
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL reset_lockstep cyc=%0d got=%b want=%b", cyc, got, want);
    end
    q1.delete();
    for (int i = 0; i < FRAME + 2; i++) begin
      cycle_step(got, want);
      n_checks++;
      if (got !== want) begin
        n_errors++;
        $display("FAIL reset_lockstep cyc=%0d got=%b want=%b", cyc, got, want);
      end
      if (i == 0) begin
        n_checks++;
        if (got[5:2] !== 4'b0101) begin
          n_errors++;
          $display("FAIL reset_first_grant cyc=%0d got txd,busy,grant=%b want 0101", cyc, got[5:2]);
        end
      end
    end
  endtask

  task automatic test_single_byte();
    logic [5:0] got, want;
    logic [9:0] pat;
    int         busy_cycles;
    bit         seen;
    pat  = {1'b1, 8'hA5, 1'b0};
    seen = 1'b0;
    q0.push_back(8'hA5);
    for (int i = 0; i < 4 && !seen; i++) begin
      cycle_step(got, want);
      n_checks++;
      if (got !== want) begin
        n_errors++;
        $display("FAIL single_lockstep cyc=%0d got=%b want=%b", cyc, got, want);
      end
      seen = hs0;
    end
    n_checks++;
    if (!seen) begin
      n_errors++;
      $display("FAIL single_handshake: ready0 got 0 for 4 cycles, want 1");
    end
    busy_cycles = 0;
    for (int j = 0; j <= FRAME; j++) begin
      cycle_step(got, want);
      n_checks++;
      if (got !== want) begin
        n_errors++;
        $display("FAIL single_lockstep cyc=%0d got=%b want=%b", cyc, got, want);
      end
      if (j < FRAME) begin
        n_checks++;
        if (got[5] !== pat[j / D]) begin
          n_errors++;
          $display("FAIL single_bit j=%0d got txd=%b want %b", j, got[5], pat[j / D]);
        end
        if (got[4] === 1'b1) busy_cycles++;
      end else begin
        n_checks++;
        if (got[4] !== 1'b0) begin
          n_errors++;
          $display("FAIL single_busy_end got busy=%b want 0", got[4]);
        end
      end
    end
    n_checks++;
    if (busy_cycles != FRAME) begin
      n_errors++;
      $display("FAIL single_frame_len got %0d busy cycles want %0d", busy_cycles, FRAME);
    end
    for (int k = 0; k < 6; k++) begin
      if ($urandom_range(0, 1) == 1) q1.push_back(8'($urandom));
      else                           q0.push_back(8'($urandom));
      for (int j = 0; j < FRAME + 3; j++) begin
        cycle_step(got, want);
        n_checks++;
        if (got !== want) begin
          n_errors++;
          $display("FAIL single_rand_lockstep cyc=%0d got=%b want=%b", cyc, got, want);
        end
      end
    end
  endtask

  task automatic test_contention();
    logic [5:0] got, want;
    logic       prev_busy;
    int         starts[$];
    logic [1:0] owners[$];
    rst_req = 1'b0;
    for (int i = 0; i < 2; i++) cycle_step(got, want);
    for (int i = 0; i < 4; i++) begin
      q0.push_back(8'(8'h11 + i));
      q1.push_back(8'(8'h22 + i));
    end
    rst_req   = 1'b1;
    prev_busy = 1'b0;
    for (int c = 0; c < 8 * (FRAME + 1) + 4; c++) begin
      cycle_step(got, want);
      n_checks++;
      if (got !== want) begin
        n_errors++;
        $display("FAIL contention_lockstep cyc=%0d got=%b want=%b", cyc, got, want);
      end
      if (got[4] === 1'b1 && prev_busy !== 1'b1) begin
        starts.push_back(c);
        owners.push_back(got[3:2]);
      end
      prev_busy = got[4];
    end
    n_checks++;
    if (starts.size() != 8) begin
      n_errors++;
      $display("FAIL contention_frames got %0d frames want 8", starts.size());
    end
    for (int k = 0; k < starts.size() && k < 8; k++) begin
      n_checks++;
      if (owners[k] !== ((k % 2 == 0) ? 2'b01 : 2'b10)) begin
        n_errors++;
        $display("FAIL contention_owner frame %0d got grant=%b want %b", k, owners[k],
                 (k % 2 == 0) ? 2'b01 : 2'b10);
      end
      if (k > 0) begin
        n_checks++;
        if (starts[k] - starts[k-1] != FRAME + 1) begin
          n_errors++;
          $display("FAIL contention_pitch frame %0d got %0d want %0d", k,
                   starts[k] - starts[k-1], FRAME + 1);
        end
      end
    end
  endtask

  task automatic test_late_arrival();
    logic [5:0] got, want;
    logic [7:0] dec, b1;
    bit         seen;
    seen = 1'b0;
    dec  = 8'h00;
    b1   = 8'($urandom);
    q0.push_back(8'h3C);
    for (int i = 0; i < 4 && !seen; i++) begin
      cycle_step(got, want);
      n_checks++;
      if (got !== want) begin
        n_errors++;
        $display("FAIL late_lockstep cyc=%0d got=%b want=%b", cyc, got, want);
      end
      seen = hs0;
    end
    n_checks++;
    if (!seen) begin
      n_errors++;
      $display("FAIL late_handshake: ready0 got 0 for 4 cycles, want 1");
    end
    for (int i = 0; i < 2 * FRAME + 4; i++) begin
      if (i == 15) q1.push_back(b1);
      cycle_step(got, want);
      n_checks++;
      if (got !== want) begin
        n_errors++;
        $display("FAIL late_lockstep cyc=%0d got=%b want=%b", cyc, got, want);
      end
      if (i < FRAME) begin
        if (i % D == D / 2 && i / D >= 1 && i / D <= 8) dec[i / D - 1] = got[5];
        n_checks++;
        if (got[3:0] !== 4'b0100) begin
          n_errors++;
          $display("FAIL late_inflight i=%0d got grant,ready=%b want 0100", i, got[3:0]);
        end
      end
      if (i == FRAME) begin
        n_checks++;
        if (got[1:0] !== 2'b10) begin
          n_errors++;
          $display("FAIL late_ready1 got ready=%b want 10", got[1:0]);
        end
      end
      if (i == FRAME + 1) begin
        n_checks++;
        if (got[3:2] !== 2'b10) begin
          n_errors++;
          $display("FAIL late_grant got grant=%b want 10", got[3:2]);
        end
      end
    end
    n_checks++;
    if (dec !== 8'h3C) begin
      n_errors++;
      $display("FAIL late_byte got %h want 3c", dec);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [5:0] got, want;
    logic [7:0] b0, b1, dec;
    bit         seen;
    int         fs, o;
    b0 = 8'($urandom);
    b1 = 8'($urandom);
    seen = 1'b0;
    q0.push_back(b0);
    for (int i = 0; i < 4 && !seen; i++) begin
      cycle_step(got, want);
      seen = hs0;
    end
    n_checks++;
    if (!seen) begin
      n_errors++;
      $display("FAIL midreset_handshake: ready0 got 0 for 4 cycles, want 1");
    end
    for (int i = 0; i < 17; i++) begin
      cycle_step(got, want);
      n_checks++;
      if (got !== want) begin
        n_errors++;
        $display("FAIL midreset_lockstep cyc=%0d got=%b want=%b", cyc, got, want);
      end
    end
    q1.push_back(b1);
    rst_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle_step(got, want);
      n_checks++;
      if (got !== want) begin
        n_errors++;
        $display("FAIL midreset_lockstep cyc=%0d got=%b want=%b", cyc, got, want);
      end
      if (i > 0) begin
        n_checks++;
        if (got !== 6'b100000) begin
          n_errors++;
          $display("FAIL midreset_hold i=%0d got=%b want=100000", i, got);
        end
      end
    end
    rst_req = 1'b1;
    fs  = -1;
    dec = 8'h00;
    for (int c = 0; c < FRAME + 4; c++) begin
      cycle_step(got, want);
      n_checks++;
      if (got !== want) begin
        n_errors++;
        $display("FAIL midreset_lockstep cyc=%0d got=%b want=%b", cyc, got, want);
      end
      if (fs < 0 && got[4] === 1'b1) fs = c;
      if (fs >= 0) begin
        o = c - fs;
        if (o % D == D / 2 && o / D >= 1 && o / D <= 8) dec[o / D - 1] = got[5];
      end
    end
    n_checks++;
    if (fs < 0 || dec !== b1) begin
      n_errors++;
      $display("FAIL midreset_fresh_byte got %h (start %0d) want %h", dec, fs, b1);
    end
  endtask

  task automatic test_random();
    logic [5:0] got, want;
    int         frames;
    frames = 0;
    for (int c = 0; c < 600; c++) begin
      if (!hs0) begin
        if (q0.size() == 0 && $urandom_range(0, 7) == 0) q0.push_back(8'($urandom));
        else if (q0.size() > 0 && $urandom_range(0, 39) == 0) q0.delete();
      end
      if (!hs1) begin
        if (q1.size() == 0 && $urandom_range(0, 7) == 0) q1.push_back(8'($urandom));
        else if (q1.size() > 0 && $urandom_range(0, 39) == 0) q1.delete();
      end
      cycle_step(got, want);
      n_checks++;
      if (got !== want) begin
        n_errors++;
        $display("FAIL rand_lockstep cyc=%0d got=%b want=%b", cyc, got, want);
      end
      if (hs0 || hs1) frames++;
    end
    for (int c = 0; c < FRAME + 2; c++) begin
      if (!hs0) q0.delete();
      if (!hs1) q1.delete();
      cycle_step(got, want);
      n_checks++;
      if (got !== want) begin
        n_errors++;
        $display("FAIL rand_lockstep cyc=%0d got=%b want=%b", cyc, got, want);
      end
    end
    n_checks++;
    if (frames < 5) begin
      n_errors++;
      $display("FAIL rand_activity got %0d frames want at least 5", frames);
    end
  endtask

  task automatic test_slow_baud();
    int         runs[$];
    logic       prev;
    int         len;
    logic [7:0] dec;
    bit         seen;
    seen = 1'b0;
    dec  = 8'h00;
    @(posedge clk); #1;
    sv0 = 1'b1;
    sd0 = 8'h55;
    for (int i = 0; i < 4 && !seen; i++) begin
      #1;
      seen = (sr0 === 1'b1);
      @(posedge clk); #1;
    end
    sv0 = 1'b0;
    sd0 = 8'($urandom);
    n_checks++;
    if (!seen) begin
      n_errors++;
      $display("FAIL slow_handshake: ready0 got 0 for 4 cycles, want 1");
    end
    #1;
    prev = stxd;
    len  = 1;
    n_checks++;
    if ({stxd, sbusy, sgrant, sr1, sr0} !== 6'b010100) begin
      n_errors++;
      $display("FAIL slow_start got txd,busy,grant,rdy=%b want 010100",
               {stxd, sbusy, sgrant, sr1, sr0});
    end
    for (int c = 1; c <= 10 * DS; c++) begin
      @(posedge clk); #2;
      if (c < 10 * DS) begin
        if (stxd === prev) len++;
        else begin
          runs.push_back(len);
          prev = stxd;
          len  = 1;
        end
        if (c % DS == DS / 2 && c / DS >= 1 && c / DS <= 8) dec[c / DS - 1] = stxd;
      end else begin
        n_checks++;
        if (sbusy !== 1'b0 || stxd !== 1'b1) begin
          n_errors++;
          $display("FAIL slow_end got busy=%b txd=%b want busy=0 txd=1", sbusy, stxd);
        end
      end
    end
    n_checks++;
    if (dec !== 8'h55) begin
      n_errors++;
      $display("FAIL slow_byte got %h want 55", dec);
    end
    n_checks++;
    if (runs.size() != 9) begin
      n_errors++;
      $display("FAIL slow_runs got %0d level runs want 9", runs.size());
    end
    for (int k = 0; k < runs.size(); k++) begin
      n_checks++;
      if (runs[k] != DS) begin
        n_errors++;
        $display("FAIL slow_bit_period run %0d got %0d cycles want %0d", k, runs[k], DS);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n   = 1'b0;
    rst_req = 1'b0;
    v0 = 1'b0; v1 = 1'b0; d0 = 8'h00; d1 = 8'h00;
    sv0 = 1'b0; sv1 = 1'b0; sd0 = 8'h00; sd1 = 8'h00;
    test_reset();
    test_single_byte();
    test_contention();
    test_late_arrival();
    test_reset_mid_frame();
    test_random();
    test_slow_baud();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
